// File: rtl/irq_pkg.sv
// Shared types and constants for the irq_arbiter interrupt controller.
package irq_pkg;

    localparam int unsigned ID_W   = 3;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_ACT  = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] REG_MASK     = 3'd0;
    localparam logic [ADDR_W-1:0] REG_PENDING  = 3'd1;
    localparam logic [ADDR_W-1:0] REG_VEC_BASE = 3'd2;
    localparam logic [ADDR_W-1:0] REG_EOI      = 3'd3;
    localparam logic [ADDR_W-1:0] REG_STATUS   = 3'd4;

    typedef struct packed {
        logic            active;
        state_t          state;
        logic [ID_W-1:0] id;
    } status_t;

    // ISR vector: base plus id scaled by the vector stride, wrapping at 32 bits.
    function automatic logic [DATA_W-1:0] vec_addr(input logic [DATA_W-1:0] base,
                                                   input logic [ID_W-1:0]   id,
                                                   input int unsigned       shift);
        return base + (DATA_W'(id) << shift);
    endfunction

endpackage

// File: rtl/irq_pick.sv
// Combinational winner picker: fixed lowest-index priority, or round-robin
// after last_id when IRQ_ROUND_ROBIN_EN is defined.
module irq_pick
    import irq_pkg::*;
#(
    parameter int unsigned N_SRC = 4
) (
    input  logic [N_SRC-1:0] req,
`ifdef IRQ_ROUND_ROBIN_EN
    input  logic [ID_W-1:0]  last_id,
`endif
    output logic             valid,
    output logic [ID_W-1:0]  id
);

`ifdef IRQ_ROUND_ROBIN_EN
    int best;

    // Rank each source by its distance upward from last_id+1; smallest rank wins.
    always_comb begin
        valid = |req;
        id    = '0;
        best  = int'(N_SRC);
        for (int i = 0; i < int'(N_SRC); i++) begin
            if (req[i] && (((i + int'(N_SRC) - 1 - int'(last_id)) % int'(N_SRC)) < best)) begin
                best = (i + int'(N_SRC) - 1 - int'(last_id)) % int'(N_SRC);
                id   = ID_W'(i);
            end
        end
    end
`else
    // Scan downward so the lowest set index is the last one written.
    always_comb begin
        valid = |req;
        id    = '0;
        for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
            if (req[i]) begin
                id = ID_W'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/irq_arbiter.sv
// Interrupt controller for the mips core: edge capture, mask, single grant
// with ack/EOI handshake. Optional IRQ_ROUND_ROBIN_EN selects round-robin winner.
module irq_arbiter
    import irq_pkg::*;
#(
    parameter int unsigned       N_SRC        = 4,
    parameter int unsigned       VEC_SHIFT    = 4,
    parameter logic [DATA_W-1:0] VEC_BASE_RST = 32'h20
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_SRC-1:0]     src_irq,
    input  logic                 bus_we,
    input  logic [ADDR_W-1:0]    bus_addr,
    input  logic [DATA_W-1:0]    bus_wd,
    output logic [DATA_W-1:0]    bus_rd,
    output logic                 irq,
    output logic [DATA_W-1:0]    irq_addr,
    input  logic                 irq_ack,
    output logic                 active
);

    localparam logic [DATA_W-1:0] VEC_KEEP = ~((DATA_W'(1) << VEC_SHIFT) - DATA_W'(1));

    logic [N_SRC-1:0]  src_q;
    logic [N_SRC-1:0]  pending;
    logic [N_SRC-1:0]  mask;
    logic [DATA_W-1:0] vec_base;
    state_t            state;
    logic [ID_W-1:0]   id;

    logic [N_SRC-1:0]  edge_set;
    logic [N_SRC-1:0]  w1c_clr;
    logic [N_SRC-1:0]  grant_clr;
    logic              ack_take;
    logic              eoi_wr;
    logic              pick_valid;
    logic [ID_W-1:0]   pick_id;
    status_t           status;

`ifdef IRQ_ROUND_ROBIN_EN
    logic [ID_W-1:0]   last_id;
`endif

    assign edge_set  = src_irq & ~src_q;
    assign w1c_clr   = (bus_we && bus_addr == REG_PENDING) ? bus_wd[N_SRC-1:0] : '0;
    assign ack_take  = (state == S_REQ) && irq_ack;
    assign grant_clr = ack_take ? (N_SRC'(1) << id) : '0;
    assign eoi_wr    = bus_we && (bus_addr == REG_EOI);

    irq_pick #(
        .N_SRC   (N_SRC)
    ) u_pick (
        .req     (pending & mask),
`ifdef IRQ_ROUND_ROBIN_EN
        .last_id (last_id),
`endif
        .valid   (pick_valid),
        .id      (pick_id)
    );

    // Previous-cycle source levels for rising-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_q <= '0;
        end else begin
            src_q <= src_irq;
        end
    end

    // A new edge wins over both software clear and grant clear in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~w1c_clr & ~grant_clr) | edge_set;
        end
    end

    // Software-writable configuration registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask     <= '0;
            vec_base <= VEC_BASE_RST & VEC_KEEP;
        end else if (bus_we) begin
            if (bus_addr == REG_MASK) begin
                mask <= bus_wd[N_SRC-1:0];
            end
            if (bus_addr == REG_VEC_BASE) begin
                vec_base <= bus_wd & VEC_KEEP;
            end
        end
    end

    // Grant FSM: request held stable until acked, service held until EOI.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            id       <= '0;
            irq      <= 1'b0;
            irq_addr <= '0;
            active   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pick_valid) begin
                        state    <= S_REQ;
                        id       <= pick_id;
                        irq      <= 1'b1;
                        irq_addr <= vec_addr(vec_base, pick_id, VEC_SHIFT);
                    end
                end
                S_REQ: begin
                    if (irq_ack) begin
                        state    <= S_ACT;
                        irq      <= 1'b0;
                        irq_addr <= '0;
                        active   <= 1'b1;
                    end
                end
                S_ACT: begin
                    if (eoi_wr) begin
                        state  <= S_IDLE;
                        active <= 1'b0;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    irq      <= 1'b0;
                    irq_addr <= '0;
                    active   <= 1'b0;
                end
            endcase
        end
    end

`ifdef IRQ_ROUND_ROBIN_EN
    // Round-robin pointer advances only when the core takes the vector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_id <= ID_W'(N_SRC - 1);
        end else if (ack_take) begin
            last_id <= id;
        end
    end
`endif

    assign status = '{active: active, state: state, id: id};

    // Register read mux, combinational on bus_addr.
    always_comb begin
        bus_rd = '0;
        case (bus_addr)
            REG_MASK:     bus_rd = DATA_W'(mask);
            REG_PENDING:  bus_rd = DATA_W'(pending);
            REG_VEC_BASE: bus_rd = vec_base;
            REG_STATUS:   bus_rd = DATA_W'(status);
            default:      bus_rd = '0;
        endcase
    end

endmodule

// File: tb/tb_irq_arbiter.sv
// Self-checking bench for irq_arbiter (default fixed-priority build).
module tb_irq_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  src_irq;
    logic        bus_we;
    logic [2:0]  bus_addr;
    logic [31:0] bus_wd;
    logic [31:0] bus_rd;
    logic        irq;
    logic [31:0] irq_addr;
    logic        irq_ack;
    logic        active;

    int n_chk  = 0;
    int n_fail = 0;

    irq_arbiter #(
        .N_SRC        (4),
        .VEC_SHIFT    (4),
        .VEC_BASE_RST (32'h20)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .src_irq  (src_irq),
        .bus_we   (bus_we),
        .bus_addr (bus_addr),
        .bus_wd   (bus_wd),
        .bus_rd   (bus_rd),
        .irq      (irq),
        .irq_addr (irq_addr),
        .irq_ack  (irq_ack),
        .active   (active)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  src;
        logic        we;
        logic [2:0]  addr;
        logic [31:0] wd;
        logic        ack;
        int          rep;
        logic        e_irq;
        logic [31:0] e_addr;
        logic        e_act;
        logic [31:0] e_rd;
    } vec_t;

    typedef struct {
        int          idx;
        logic        e_irq;
        logic [31:0] e_addr;
        logic        e_act;
        logic [31:0] e_rd;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    function automatic vec_t mk(logic [3:0] src, logic we, logic [2:0] addr, logic [31:0] wd,
                                logic ack, int rep, logic e_irq, logic [31:0] e_addr,
                                logic e_act, logic [31:0] e_rd);
        vec_t v;
        v.src = src; v.we = we; v.addr = addr; v.wd = wd; v.ack = ack; v.rep = rep;
        v.e_irq = e_irq; v.e_addr = e_addr; v.e_act = e_act; v.e_rd = e_rd;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (step %0d): got %h expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic rd_chk(input string nm, input logic [2:0] a, input logic [31:0] exp);
        bus_addr = a;
        #1;
        chk(nm, -1, bus_rd, exp);
    endtask

    initial begin
        rst = 1'b1; src_irq = '0; bus_we = 1'b0; bus_addr = '0; bus_wd = '0; irq_ack = 1'b0;

        //        src  we addr wd            ack rep irq addr          act rd
        // Single source, full handshake
        tbl.push_back(mk(4'h0, 1, 3'd0, 32'hF,        0, 1, 0, 32'h0,        0, 32'hF));
        tbl.push_back(mk(4'h4, 0, 3'd1, 32'h0,        0, 1, 0, 32'h0,        0, 32'h4));
        tbl.push_back(mk(4'h4, 0, 3'd1, 32'h0,        0, 1, 1, 32'h40,       0, 32'h4));
        tbl.push_back(mk(4'h0, 0, 3'd4, 32'h0,        0, 1, 1, 32'h40,       0, 32'h0A));
        tbl.push_back(mk(4'h0, 0, 3'd1, 32'h0,        1, 1, 0, 32'h0,        1, 32'h0));
        tbl.push_back(mk(4'h0, 0, 3'd4, 32'h0,        0, 1, 0, 32'h0,        1, 32'h32));
        tbl.push_back(mk(4'h0, 1, 3'd3, 32'h0,        0, 1, 0, 32'h0,        0, 32'h0));
        tbl.push_back(mk(4'h0, 0, 3'd4, 32'h0,        0, 1, 0, 32'h0,        0, 32'h02));
        // Two simultaneous sources, lowest index first
        tbl.push_back(mk(4'hA, 0, 3'd1, 32'h0,        0, 1, 0, 32'h0,        0, 32'hA));
        tbl.push_back(mk(4'h0, 0, 3'd1, 32'h0,        0, 1, 1, 32'h30,       0, 32'hA));
        tbl.push_back(mk(4'h0, 0, 3'd1, 32'h0,        1, 1, 0, 32'h0,        1, 32'h8));
        tbl.push_back(mk(4'h0, 1, 3'd3, 32'h0,        0, 1, 0, 32'h0,        0, 32'h0));
        tbl.push_back(mk(4'h0, 0, 3'd1, 32'h0,        0, 1, 1, 32'h50,       0, 32'h8));
        tbl.push_back(mk(4'h0, 0, 3'd1, 32'h0,        1, 1, 0, 32'h0,        1, 32'h0));
        tbl.push_back(mk(4'h0, 1, 3'd3, 32'h0,        0, 1, 0, 32'h0,        0, 32'h0));
        // Masked source stays pending, released by a MASK write
        tbl.push_back(mk(4'h0, 1, 3'd0, 32'h0,        0, 1, 0, 32'h0,        0, 32'h0));
        tbl.push_back(mk(4'h1, 0, 3'd1, 32'h0,        0, 1, 0, 32'h0,        0, 32'h1));
        tbl.push_back(mk(4'h0, 0, 3'd1, 32'h0,        0, 10, 0, 32'h0,       0, 32'h1));
        tbl.push_back(mk(4'h0, 1, 3'd0, 32'h1,        0, 1, 0, 32'h0,        0, 32'h1));
        tbl.push_back(mk(4'h0, 0, 3'd1, 32'h0,        0, 1, 1, 32'h20,       0, 32'h1));
        tbl.push_back(mk(4'h0, 0, 3'd1, 32'h0,        1, 1, 0, 32'h0,        1, 32'h0));
        tbl.push_back(mk(4'h0, 1, 3'd3, 32'h0,        0, 1, 0, 32'h0,        0, 32'h0));
        // Re-trigger while in service: no nesting, re-issued after EOI
        tbl.push_back(mk(4'h0, 1, 3'd0, 32'hF,        0, 1, 0, 32'h0,        0, 32'hF));
        tbl.push_back(mk(4'h4, 0, 3'd1, 32'h0,        0, 1, 0, 32'h0,        0, 32'h4));
        tbl.push_back(mk(4'h0, 0, 3'd1, 32'h0,        0, 1, 1, 32'h40,       0, 32'h4));
        tbl.push_back(mk(4'h0, 0, 3'd1, 32'h0,        1, 1, 0, 32'h0,        1, 32'h0));
        tbl.push_back(mk(4'h4, 0, 3'd1, 32'h0,        0, 1, 0, 32'h0,        1, 32'h4));
        tbl.push_back(mk(4'h0, 0, 3'd1, 32'h0,        0, 3, 0, 32'h0,        1, 32'h4));
        tbl.push_back(mk(4'h0, 1, 3'd3, 32'h0,        0, 1, 0, 32'h0,        0, 32'h0));
        tbl.push_back(mk(4'h0, 0, 3'd1, 32'h0,        0, 1, 1, 32'h40,       0, 32'h4));
        tbl.push_back(mk(4'h0, 0, 3'd1, 32'h0,        1, 1, 0, 32'h0,        1, 32'h0));
        tbl.push_back(mk(4'h0, 1, 3'd3, 32'h0,        0, 1, 0, 32'h0,        0, 32'h0));
        // Set beats W1C in the same cycle
        tbl.push_back(mk(4'h0, 1, 3'd0, 32'h0,        0, 1, 0, 32'h0,        0, 32'h0));
        tbl.push_back(mk(4'h1, 0, 3'd1, 32'h0,        0, 1, 0, 32'h0,        0, 32'h1));
        tbl.push_back(mk(4'h2, 1, 3'd1, 32'h3,        0, 1, 0, 32'h0,        0, 32'h2));
        tbl.push_back(mk(4'h2, 1, 3'd1, 32'h2,        0, 1, 0, 32'h0,        0, 32'h0));
        // Set beats grant-clear; REQ holds across a MASK change; ack in IDLE ignored
        tbl.push_back(mk(4'h0, 1, 3'd0, 32'hF,        0, 1, 0, 32'h0,        0, 32'hF));
        tbl.push_back(mk(4'h4, 0, 3'd1, 32'h0,        0, 1, 0, 32'h0,        0, 32'h4));
        tbl.push_back(mk(4'h0, 0, 3'd1, 32'h0,        0, 1, 1, 32'h40,       0, 32'h4));
        tbl.push_back(mk(4'h4, 0, 3'd1, 32'h0,        1, 1, 0, 32'h0,        1, 32'h4));
        tbl.push_back(mk(4'h0, 1, 3'd3, 32'h0,        0, 1, 0, 32'h0,        0, 32'h0));
        tbl.push_back(mk(4'h0, 0, 3'd1, 32'h0,        0, 1, 1, 32'h40,       0, 32'h4));
        tbl.push_back(mk(4'h0, 1, 3'd0, 32'h0,        0, 1, 1, 32'h40,       0, 32'h0));
        tbl.push_back(mk(4'h0, 0, 3'd1, 32'h0,        1, 1, 0, 32'h0,        1, 32'h0));
        tbl.push_back(mk(4'h0, 1, 3'd3, 32'h0,        0, 1, 0, 32'h0,        0, 32'h0));
        tbl.push_back(mk(4'h0, 0, 3'd4, 32'h0,        1, 1, 0, 32'h0,        0, 32'h02));
        // VEC_BASE low bits forced to zero, vector add wraps; EOI in REQ ignored
        tbl.push_back(mk(4'h0, 1, 3'd2, 32'hFFFFFFF7, 0, 1, 0, 32'h0,        0, 32'hFFFFFFF0));
        tbl.push_back(mk(4'h0, 1, 3'd0, 32'hF,        0, 1, 0, 32'h0,        0, 32'hF));
        tbl.push_back(mk(4'h8, 0, 3'd1, 32'h0,        0, 1, 0, 32'h0,        0, 32'h8));
        tbl.push_back(mk(4'h0, 0, 3'd1, 32'h0,        0, 1, 1, 32'h20,       0, 32'h8));
        tbl.push_back(mk(4'h0, 1, 3'd3, 32'h0,        0, 1, 1, 32'h20,       0, 32'h0));
        tbl.push_back(mk(4'h0, 0, 3'd4, 32'h0,        0, 1, 1, 32'h20,       0, 32'h0B));
        tbl.push_back(mk(4'h0, 0, 3'd1, 32'h0,        1, 1, 0, 32'h0,        1, 32'h0));
        tbl.push_back(mk(4'h0, 1, 3'd3, 32'h0,        0, 1, 0, 32'h0,        0, 32'h0));
        // Unused addresses read zero and ignore writes
        tbl.push_back(mk(4'h0, 1, 3'd5, 32'hFFFFFFFF, 0, 1, 0, 32'h0,        0, 32'h0));
        tbl.push_back(mk(4'h0, 0, 3'd7, 32'h0,        0, 1, 0, 32'h0,        0, 32'h0));
        tbl.push_back(mk(4'h0, 0, 3'd0, 32'h0,        0, 1, 0, 32'h0,        0, 32'hF));
        // Bring a request up for the async reset case
        tbl.push_back(mk(4'h0, 1, 3'd2, 32'h20,       0, 1, 0, 32'h0,        0, 32'h20));
        tbl.push_back(mk(4'h1, 0, 3'd1, 32'h0,        0, 1, 0, 32'h0,        0, 32'h1));
        tbl.push_back(mk(4'h0, 0, 3'd1, 32'h0,        0, 1, 1, 32'h20,       0, 32'h1));

        // Reset values
        #2;
        chk("rst_irq", -1, 32'(irq), 32'h0);
        chk("rst_irq_addr", -1, irq_addr, 32'h0);
        chk("rst_active", -1, 32'(active), 32'h0);
        rd_chk("rst_mask", 3'd0, 32'h0);
        rd_chk("rst_vec_base", 3'd2, 32'h20);
        rd_chk("rst_status", 3'd4, 32'h0);
        rd_chk("rst_pending", 3'd1, 32'h0);

        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) begin
            for (int r = 0; r < tbl[i].rep; r++) begin
                exp_t e;
                src_irq  = tbl[i].src;
                bus_we   = tbl[i].we;
                bus_addr = tbl[i].addr;
                bus_wd   = tbl[i].wd;
                irq_ack  = tbl[i].ack;
                e.idx = i; e.e_irq = tbl[i].e_irq; e.e_addr = tbl[i].e_addr;
                e.e_act = tbl[i].e_act; e.e_rd = tbl[i].e_rd;
                sb.push_back(e);
                @(posedge clk);
                #1;
                if (sb.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL scoreboard_empty (step %0d): got 0 entries expected 1", i);
                end else begin
                    e = sb.pop_front();
                    chk("irq", e.idx, 32'(irq), 32'(e.e_irq));
                    chk("irq_addr", e.idx, irq_addr, e.e_addr);
                    chk("active", e.idx, 32'(active), 32'(e.e_act));
                    chk("bus_rd", e.idx, bus_rd, e.e_rd);
                end
            end
        end
        bus_we = 1'b0; irq_ack = 1'b0; src_irq = '0;

        // Async reset mid-cycle while a request is up
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async_rst_irq", -1, 32'(irq), 32'h0);
        chk("async_rst_irq_addr", -1, irq_addr, 32'h0);
        chk("async_rst_active", -1, 32'(active), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_irq", -1, 32'(irq), 32'h0);
        rd_chk("post_rst_pending", 3'd1, 32'h0);
        rd_chk("post_rst_status", 3'd4, 32'h0);
        rd_chk("post_rst_mask", 3'd0, 32'h0);
        rd_chk("post_rst_vec_base", 3'd2, 32'h20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
